// File: rtl/enemy_inflate_ctrl.sv
// enemy_inflate_ctrl
//   One enemy. It roams inside a bounding box on one axis and inflates one
//   level per pump hit. It deflates on a frame timer when hits stop, pops at
//   POP_LEVEL, and after the pop animation it reports itself for deletion.
// Ports
//   Clk, Reset                 clock, synchronous active-high reset
//   frame_clk                  vsync level; its rising edge is the frame tick
//   DrawX, DrawY               pixel currently being drawn
//   Start_X, Start_Y           spawn position, loaded while Reset is high
//   Min_X/Max_X, Min_Y/Max_Y   roaming bounds
//   hori0_verti1               roaming axis (0 horizontal, 1 vertical)
//   Pump_X, Pump_Y             pump head centre
//   Pump_enable                pump head active
//   pump_hit                   one-Clk pulse per pump press
//   is_Enemy                   current pixel lies inside the live sprite box
//   Enemy_X_Loc, Enemy_Y_Loc   position registers
//   Enemy_attacked             pump box overlaps the enemy box while it can be hit
//   inflate_level              0..POP_LEVEL, used to pick the sprite
//   popping, Delete_enemy      state is POPPING / DEAD
//   o_state                    debug view of the FSM state
module enemy_inflate_ctrl #(
    parameter logic [9:0] HALF_SIZE      = 10'd8,
    parameter logic [9:0] STEP           = 10'd1,
    parameter logic [2:0] POP_LEVEL      = 3'd4,
    parameter logic [7:0] DEFLATE_FRAMES = 8'd30,
    parameter logic [7:0] POP_FRAMES     = 8'd60
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic [9:0] Start_X,
    input  logic [9:0] Start_Y,
    input  logic [9:0] Min_X,
    input  logic [9:0] Max_X,
    input  logic [9:0] Min_Y,
    input  logic [9:0] Max_Y,
    input  logic       hori0_verti1,
    input  logic [9:0] Pump_X,
    input  logic [9:0] Pump_Y,
    input  logic       Pump_enable,
    input  logic       pump_hit,
    output logic       is_Enemy,
    output logic [9:0] Enemy_X_Loc,
    output logic [9:0] Enemy_Y_Loc,
    output logic       Enemy_attacked,
    output logic [2:0] inflate_level,
    output logic       popping,
    output logic       Delete_enemy,
    output logic [1:0] o_state
);

    typedef enum logic [1:0] {ST_ROAM, ST_INFLATED, ST_POPPING, ST_DEAD} state_t;

    // Comparisons are done at 11 bits so adding a span never wraps.
    localparam logic [10:0] L_HALF = {1'b0, HALF_SIZE};
    localparam logic [10:0] L_SPAN = {HALF_SIZE, 1'b0};
    localparam logic [10:0] L_STEP = {1'b0, STEP};

    state_t     r_state, w_state_nxt;
    logic       r_frame_clk_d;
    logic [9:0] r_pos_x, r_pos_y, r_motion_x, r_motion_y;
    logic [9:0] w_pos_x_nxt, w_pos_y_nxt, w_motion_x_nxt, w_motion_y_nxt;
    logic [2:0] r_level, w_level_nxt, w_level_inc;
    logic [7:0] r_deflate_cnt, w_deflate_cnt_nxt, w_deflate_inc;
    logic [7:0] r_pop_cnt, w_pop_cnt_nxt, w_pop_inc;
    logic [9:0] w_dir;
    logic       w_fr, w_overlap, w_in_sprite, w_attacked, w_hit;

    assign w_fr = frame_clk & ~r_frame_clk_d;

    assign w_overlap = ({1'b0, r_pos_x} + L_SPAN >= {1'b0, Pump_X}) &&
                       ({1'b0, r_pos_x} <= {1'b0, Pump_X} + L_SPAN) &&
                       ({1'b0, r_pos_y} + L_SPAN >= {1'b0, Pump_Y}) &&
                       ({1'b0, r_pos_y} <= {1'b0, Pump_Y} + L_SPAN);

    assign w_in_sprite = ({1'b0, DrawX} + L_HALF >= {1'b0, r_pos_x}) &&
                         ({1'b0, DrawX} <= {1'b0, r_pos_x} + L_HALF) &&
                         ({1'b0, DrawY} + L_HALF >= {1'b0, r_pos_y}) &&
                         ({1'b0, DrawY} <= {1'b0, r_pos_y} + L_HALF);

    assign w_hit         = pump_hit & w_attacked;
    assign w_level_inc   = r_level + 3'd1;
    assign w_deflate_inc = r_deflate_cnt + 8'd1;
    assign w_pop_inc     = r_pop_cnt + 8'd1;

    // State and datapath registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state       <= ST_ROAM;
            r_frame_clk_d <= 1'b0;
            r_pos_x       <= Start_X;
            r_pos_y       <= Start_Y;
            r_motion_x    <= hori0_verti1 ? 10'd0 : (10'd0 - STEP);
            r_motion_y    <= hori0_verti1 ? STEP : 10'd0;
            r_level       <= 3'd0;
            r_deflate_cnt <= 8'd0;
            r_pop_cnt     <= 8'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_frame_clk_d <= frame_clk;
            r_pos_x       <= w_pos_x_nxt;
            r_pos_y       <= w_pos_y_nxt;
            r_motion_x    <= w_motion_x_nxt;
            r_motion_y    <= w_motion_y_nxt;
            r_level       <= w_level_nxt;
            r_deflate_cnt <= w_deflate_cnt_nxt;
            r_pop_cnt     <= w_pop_cnt_nxt;
        end
    end

    // Next state and datapath
    always_comb begin
        w_state_nxt       = r_state;
        w_pos_x_nxt       = r_pos_x;
        w_pos_y_nxt       = r_pos_y;
        w_motion_x_nxt    = r_motion_x;
        w_motion_y_nxt    = r_motion_y;
        w_level_nxt       = r_level;
        w_deflate_cnt_nxt = r_deflate_cnt;
        w_pop_cnt_nxt     = r_pop_cnt;
        w_dir             = hori0_verti1 ? r_motion_y : r_motion_x;
        case (r_state)
            ST_ROAM: begin
                // A hit freezes the enemy; it does not also move on that frame.
                if (w_hit) begin
                    w_level_nxt       = 3'd1;
                    w_deflate_cnt_nxt = 8'd0;
                    w_state_nxt       = ST_INFLATED;
                end else if (w_fr) begin
                    // Bounce first, then step with the (possibly new) direction.
                    if (!hori0_verti1) begin
                        if ({1'b0, r_pos_x} + L_STEP >= {1'b0, Max_X})
                            w_dir = 10'd0 - STEP;
                        else if ({1'b0, r_pos_x} <= {1'b0, Min_X} + L_STEP)
                            w_dir = STEP;
                        w_motion_x_nxt = w_dir;
                        w_pos_x_nxt    = r_pos_x + w_dir;
                    end else begin
                        if ({1'b0, r_pos_y} + L_STEP >= {1'b0, Max_Y})
                            w_dir = 10'd0 - STEP;
                        else if ({1'b0, r_pos_y} <= {1'b0, Min_Y} + L_STEP)
                            w_dir = STEP;
                        w_motion_y_nxt = w_dir;
                        w_pos_y_nxt    = r_pos_y + w_dir;
                    end
                end
            end
            ST_INFLATED: begin
                // A hit outranks a coincident frame tick.
                if (w_hit) begin
                    w_level_nxt       = w_level_inc;
                    w_deflate_cnt_nxt = 8'd0;
                    if (w_level_inc == POP_LEVEL) begin
                        w_state_nxt   = ST_POPPING;
                        w_pop_cnt_nxt = 8'd0;
                    end
                end else if (w_fr) begin
                    if (w_deflate_inc == DEFLATE_FRAMES) begin
                        w_level_nxt       = r_level - 3'd1;
                        w_deflate_cnt_nxt = 8'd0;
                        // Motion registers are untouched, so roaming resumes
                        // in the direction it had before inflating.
                        if (r_level == 3'd1)
                            w_state_nxt = ST_ROAM;
                    end else begin
                        w_deflate_cnt_nxt = w_deflate_inc;
                    end
                end
            end
            ST_POPPING: begin
                w_level_nxt = POP_LEVEL;
                if (w_fr) begin
                    w_pop_cnt_nxt = w_pop_inc;
                    if (w_pop_inc == POP_FRAMES)
                        w_state_nxt = ST_DEAD;
                end
            end
            default: begin
                w_state_nxt = ST_DEAD;
            end
        endcase
    end

    // Outputs
    always_comb begin
        w_attacked     = w_overlap && Pump_enable &&
                         (r_state == ST_ROAM || r_state == ST_INFLATED);
        Enemy_attacked = w_attacked;
        is_Enemy       = w_in_sprite && (r_state != ST_DEAD);
        Enemy_X_Loc    = r_pos_x;
        Enemy_Y_Loc    = r_pos_y;
        inflate_level  = r_level;
        popping        = (r_state == ST_POPPING);
        Delete_enemy   = (r_state == ST_DEAD);
        o_state        = r_state;
    end

endmodule
